// File: rtl/hiddencpu_fetch_pkg.sv
// Shared definitions for the HiddenCPU instruction-supply stage:
// state encoding, the reset instruction word and the default word width.
package hiddencpu_fetch_pkg;

  localparam int IW_DEFAULT = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RUN  = ST_RUN,
    HALT = ST_HALT
  } fetchStateT;

  localparam logic [IW_DEFAULT-1:0] NOP_WORD = 6'b000000;

endpackage

// File: rtl/hiddencpu_fetch_if.sv
// Host-load, core-feedback and instruction-issue signals of the fetch stage.
// master = host/core side, slave = the fetch stage itself.
interface hiddencpu_fetch_if
  import hiddencpu_fetch_pkg::*;
#(
  parameter int AW = 4,
  parameter int IW = IW_DEFAULT
) ();

  logic          load_en;
  logic          load_valid;
  logic [IW-1:0] load_data;
  logic          run;
  logic          stall;
  logic          br_taken;
  logic [7:0]    br_offset;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic [AW-1:0] issue_addr;
  logic [AW:0]   prog_len;
  logic          halted;
  logic          overflow;

  modport master (
    output load_en, load_valid, load_data, run, stall, br_taken, br_offset,
    input  instr_out, instr_valid, issue_addr, prog_len, halted, overflow
  );

  modport slave (
    input  load_en, load_valid, load_data, run, stall, br_taken, br_offset,
    output instr_out, instr_valid, issue_addr, prog_len, halted, overflow
  );

endinterface

// File: rtl/hiddencpu_prog_ram.sv
// Program store: DEPTH x IW, one synchronous write port and one registered
// read port whose read-enable lets a stalled core keep its current word.
module hiddencpu_prog_ram
  import hiddencpu_fetch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = IW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wAddr,
  input  logic [IW-1:0] wData,
  input  logic          re,
  input  logic [AW-1:0] rAddr,
  output logic [IW-1:0] rData
);

  logic [IW-1:0] mem [DEPTH];

  // Write port; contents survive reset by design
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
  end

  // Registered read port, resets to the NOP word seen by the core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rData <= IW'(NOP_WORD);
    end else if (re) begin
      rData <= mem[rAddr];
    end
  end

endmodule

// File: rtl/hiddencpu_fetch.sv
// HiddenCPU fetch stage: host program load, then replay to the core with
// stall and zero-bubble branch support. Define HIDDENCPU_FETCH_LOOP_EN to wrap.
module hiddencpu_fetch
  import hiddencpu_fetch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = IW_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  hiddencpu_fetch_if.slave  bus
);

  localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

  fetchStateT    state;
  fetchStateT    stateNext;
  logic [AW-1:0] issueAddr;
  logic [AW-1:0] issueNext;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] wrPtrNext;
  logic [AW-1:0] ramRaddr;
  logic [AW-1:0] brTarget;
  logic [AW:0]   progLen;
  logic [AW:0]   progLenNext;
  logic [AW:0]   candNext;
  logic          instrValid;
  logic          validNext;
  logic          overflowR;
  logic          ovfNext;
  logic          haltedR;
  logic          haltedNext;
  logic          ramWe;
  logic          ramRe;
  logic          atEnd;
  logic [IW-1:0] ramRdata;
  logic          unusedBrHi;

  hiddencpu_prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ramWe),
    .wAddr (wrPtr),
    .wData (bus.load_data),
    .re    (ramRe),
    .rAddr (ramRaddr),
    .rData (ramRdata)
  );

  // Branch target wraps mod DEPTH, so only the low offset bits matter
  assign brTarget   = issueAddr + bus.br_offset[AW-1:0];
  assign unusedBrHi = ^bus.br_offset[7:AW];
  assign candNext   = bus.br_taken ? {1'b0, brTarget}
                                   : ({1'b0, issueAddr} + {{AW{1'b0}}, 1'b1});
  assign atEnd      = (candNext >= progLen);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state, pointer and store-control decode
  always_comb begin
    stateNext   = state;
    issueNext   = issueAddr;
    wrPtrNext   = wrPtr;
    progLenNext = progLen;
    validNext   = instrValid;
    ovfNext     = overflowR;
    haltedNext  = haltedR;
    ramWe       = 1'b0;
    ramRe       = 1'b0;
    ramRaddr    = issueAddr;
    case (state)
      IDLE: begin
        validNext  = 1'b0;
        haltedNext = 1'b0;
        if (bus.load_en) begin
          stateNext   = LOAD;
          progLenNext = {(AW+1){1'b0}};
          wrPtrNext   = {AW{1'b0}};
          ovfNext     = 1'b0;
        end else if (bus.run && (progLen != {(AW+1){1'b0}})) begin
          stateNext = RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      LOAD: begin
        if (!bus.load_en) begin
          stateNext = IDLE;
        end else if (bus.load_valid) begin
          if (progLen < DEPTH_LEN) begin
            ramWe       = 1'b1;
            wrPtrNext   = wrPtr + {{(AW-1){1'b0}}, 1'b1};
            progLenNext = progLen + {{AW{1'b0}}, 1'b1};
          end else begin
            ovfNext = 1'b1;
          end
        end else begin
          stateNext = LOAD;
        end
      end
      RUN: begin
        if (!bus.run) begin
          stateNext = IDLE;
          validNext = 1'b0;
        end else if (!instrValid) begin
          // First cycle in RUN: fetch word 0
          ramRe     = 1'b1;
          ramRaddr  = {AW{1'b0}};
          issueNext = {AW{1'b0}};
          validNext = 1'b1;
        end else if (bus.stall) begin
          stateNext = RUN;
        end else if (atEnd) begin
`ifdef HIDDENCPU_FETCH_LOOP_EN
          ramRe     = 1'b1;
          ramRaddr  = {AW{1'b0}};
          issueNext = {AW{1'b0}};
`else
          stateNext  = HALT;
          validNext  = 1'b0;
          haltedNext = 1'b1;
`endif
        end else begin
          ramRe     = 1'b1;
          ramRaddr  = candNext[AW-1:0];
          issueNext = candNext[AW-1:0];
        end
      end
      HALT: begin
        validNext  = 1'b0;
        haltedNext = 1'b1;
        if (!bus.run) begin
          stateNext  = IDLE;
          haltedNext = 1'b0;
        end else begin
          stateNext = HALT;
        end
      end
      default: begin
        stateNext  = IDLE;
        validNext  = 1'b0;
        haltedNext = 1'b0;
      end
    endcase
  end

  // Datapath registers behind every registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issueAddr  <= {AW{1'b0}};
      wrPtr      <= {AW{1'b0}};
      progLen    <= {(AW+1){1'b0}};
      instrValid <= 1'b0;
      overflowR  <= 1'b0;
      haltedR    <= 1'b0;
    end else begin
      issueAddr  <= issueNext;
      wrPtr      <= wrPtrNext;
      progLen    <= progLenNext;
      instrValid <= validNext;
      overflowR  <= ovfNext;
      haltedR    <= haltedNext;
    end
  end

  assign bus.instr_out   = ramRdata;
  assign bus.instr_valid = instrValid;
  assign bus.issue_addr  = issueAddr;
  assign bus.prog_len    = progLen;
  assign bus.overflow    = overflowR;
`ifdef HIDDENCPU_FETCH_LOOP_EN
  assign bus.halted      = 1'b0;
`else
  assign bus.halted      = haltedR;
`endif

endmodule

// File: tb/tb_hiddencpu_fetch.sv
// Self-checking bench for hiddencpu_fetch: directed scenarios plus randomized
// replay checked against a program-level reference model.
module tb_hiddencpu_fetch;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 6;
`ifdef HIDDENCPU_FETCH_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hiddencpu_fetch_if #(.AW(AW), .IW(IW)) bus ();

  hiddencpu_fetch #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  logic [IW-1:0] progBuf [32];
  int progN;
  logic [IW-1:0] modelMem [DEPTH];
  int modelLen;
  bit modelOvf;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.load_en    = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 6'h00;
    bus.run        = 1'b0;
    bus.stall      = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_offset  = 8'h00;
  endtask

  task automatic checkAllZero(input string name);
    checks++;
    if (bus.instr_out !== 6'h00 || bus.instr_valid !== 1'b0 || bus.issue_addr !== 4'h0 ||
        bus.prog_len !== 5'h00 || bus.halted !== 1'b0 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL %s: instr=%h valid=%b addr=%0d len=%0d halted=%b ovf=%b, required all 0",
               name, bus.instr_out, bus.instr_valid, bus.issue_addr, bus.prog_len,
               bus.halted, bus.overflow);
    end
  endtask

  task automatic test_reset();
    idleInputs();
    #2 rst_n = 1'b0;
    #3;
    checkAllZero("reset_async");
    step();
    step();
    rst_n = 1'b1;
    step();
    checkAllZero("reset_release");
    bus.run = 1'b1;
    step();
    step();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.prog_len !== 5'h00) begin
      failures++;
      $display("FAIL run_empty: valid=%b len=%0d, required valid=0 len=0",
               bus.instr_valid, bus.prog_len);
    end
    bus.run = 1'b0;
    step();
  endtask

  // Loads progBuf[0..progN-1]; a trailing load_valid with load_en low must be ignored
  task automatic loadProg();
    bus.load_en = 1'b1;
    step();
    for (int i = 0; i < progN; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = progBuf[i];
      step();
    end
    bus.load_en    = 1'b0;
    bus.load_data  = 6'h3F;
    step();
    bus.load_valid = 1'b0;
    step();
    modelLen = (progN > DEPTH) ? DEPTH : progN;
    for (int i = 0; i < modelLen; i++) modelMem[i] = progBuf[i];
    modelOvf = (progN > DEPTH);
    checks++;
    if (bus.prog_len !== 5'(modelLen) || bus.overflow !== modelOvf) begin
      failures++;
      $display("FAIL load: len=%0d ovf=%b, required len=%0d ovf=%b",
               bus.prog_len, bus.overflow, modelLen, modelOvf);
    end
  endtask

  // mode 0 random, 1 stall at addr 2, 2 branch at addr 5, 3 plain replay
  task automatic runCheck(input int cycles, input int mode, input logic [7:0] brOff,
                          input int expAfter, input string name);
    int phase;
    int mAddr;
    int nxt;
    int stallsDone;
    int addr2Seen;
    int got;
    bit brDone;
    bit pendingAfter;
    logic s;
    logic b;
    logic [7:0] o;
    phase = 0; mAddr = 0; stallsDone = 0; addr2Seen = 0; brDone = 0; pendingAfter = 0;
    bus.run = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      s = 1'b0; b = 1'b0; o = 8'h00;
      case (mode)
        0: begin
          s = ($urandom_range(0, 3) == 0);
          b = ($urandom_range(0, 3) == 0);
          o = 8'($urandom);
        end
        1: if (phase == 2 && mAddr == 2 && stallsDone < 3) begin
          s = 1'b1; b = 1'b1; o = 8'h03; stallsDone++;
        end
        2: if (phase == 2 && mAddr == 5 && !brDone) begin
          b = 1'b1; o = brOff; brDone = 1'b1; pendingAfter = 1'b1;
        end
        default: ;
      endcase
      bus.stall = s; bus.br_taken = b; bus.br_offset = o;
      step();
      case (phase)
        0: phase = 1;
        1: begin phase = 2; mAddr = 0; end
        2: if (!s) begin
          nxt = b ? ((mAddr + int'(o)) % DEPTH) : (mAddr + 1);
          if (nxt >= modelLen) begin
            if (LOOP) mAddr = 0;
            else phase = 3;
          end else begin
            mAddr = nxt;
          end
        end
        default: ;
      endcase
      checks++;
      if (bus.instr_valid !== (phase == 2) || bus.halted !== (phase == 3)) begin
        failures++;
        $display("FAIL %s_status c=%0d: valid=%b halted=%b, required valid=%b halted=%b",
                 name, c, bus.instr_valid, bus.halted, (phase == 2), (phase == 3));
      end
      if (phase == 2) begin
        checks++;
        if (bus.issue_addr !== 4'(mAddr) || bus.instr_out !== modelMem[mAddr]) begin
          failures++;
          $display("FAIL %s_issue c=%0d: addr=%0d instr=%h, required addr=%0d instr=%h",
                   name, c, bus.issue_addr, bus.instr_out, mAddr, modelMem[mAddr]);
        end
      end
      if (bus.instr_valid === 1'b1 && bus.issue_addr === 4'h2) addr2Seen++;
      if (pendingAfter) begin
        pendingAfter = 1'b0;
        got = (bus.instr_valid === 1'b1) ? int'(bus.issue_addr) : -1;
        checks++;
        if (got != expAfter) begin
          failures++;
          $display("FAIL %s_target: got %0d (-1 = no issue), required %0d", name, got, expAfter);
        end
      end
    end
    if (mode == 1) begin
      checks++;
      if (addr2Seen != 4) begin
        failures++;
        $display("FAIL %s_hold: addr 2 shown %0d cycles, required 4", name, addr2Seen);
      end
    end
    if (mode == 2) begin
      checks++;
      if (!brDone) begin
        failures++;
        $display("FAIL %s_reach: branch point addr 5 reached=%b, required 1", name, brDone);
      end
    end
    idleInputs();
    step();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b0) begin
      failures++;
      $display("FAIL %s_stop: valid=%b halted=%b, required 0 0", name, bus.instr_valid, bus.halted);
    end
    step();
  endtask

  task automatic randomProg(input int n);
    progN = n;
    for (int i = 0; i < n; i++) progBuf[i] = 6'($urandom);
  endtask

  task automatic test_basic();
    progN = 3;
    progBuf[0] = 6'h11; progBuf[1] = 6'h22; progBuf[2] = 6'h33;
    loadProg();
    runCheck(6, 3, 8'h00, 0, "basic");
    checks++;
    if (bus.prog_len !== 5'd3) begin
      failures++;
      $display("FAIL basic_len: len=%0d, required 3", bus.prog_len);
    end
  endtask

  task automatic test_overflow();
    randomProg(17);
    loadProg();
    runCheck(22, 3, 8'h00, 0, "overflow");
  endtask

  task automatic test_stall();
    randomProg(8);
    loadProg();
    runCheck(14, 1, 8'h00, 0, "stall");
  endtask

  task automatic test_branch();
    randomProg(8);
    loadProg();
    runCheck(12, 2, 8'hFE, 3, "br_back");
    runCheck(12, 2, 8'd4, LOOP ? 0 : -1, "br_end");
  endtask

  task automatic test_reset_mid_run();
    randomProg(8);
    loadProg();
    bus.run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_valid === 1'b1 && bus.issue_addr === 4'h4) break;
      step();
    end
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.issue_addr !== 4'h4) begin
      failures++;
      $display("FAIL midrun_reach: valid=%b addr=%0d, required 1 4", bus.instr_valid, bus.issue_addr);
    end
    rst_n = 1'b0;
    #1;
    checkAllZero("midrun_reset");
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.prog_len !== 5'h00) begin
      failures++;
      $display("FAIL midrun_after: valid=%b len=%0d, required 0 0", bus.instr_valid, bus.prog_len);
    end
    idleInputs();
    step();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      randomProg($urandom_range(1, DEPTH));
      loadProg();
      runCheck(40, 0, 8'h00, 0, "random");
    end
  endtask

`ifdef HIDDENCPU_FETCH_LOOP_EN
  task automatic test_loop();
    progN = 2;
    progBuf[0] = 6'h05; progBuf[1] = 6'h0A;
    loadProg();
    runCheck(12, 3, 8'h00, 0, "loop");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_branch();
    test_reset_mid_run();
    test_random();
`ifdef HIDDENCPU_FETCH_LOOP_EN
    test_loop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hiddencpu_fetch.md
Name: hiddencpu_fetch

Overview:
- Instruction-supply stage directly upstream of the HiddenCPU core; replaces raw pin-driven instruction entry.
- A host loads a short program of 6-bit instruction words (opcode[5:4], regA[3:2], regB[1:0]) into a small on-chip program store.
- In run mode the stage replays the program to the core one word per cycle, honouring core stall and taken-branch feedback.

Parameters:
- DEPTH, 16, program store depth in words (power of 2).
- AW, 4, address width, log2(DEPTH).
- IW, 6, instruction word width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load_en  input  1  level: host program-load session active.
- load_valid  input  1  qualifies load_data this cycle.
- load_data  input  IW  instruction word to store.
- run  input  1  level: replay program to core.
- stall  input  1  core not ready; freeze issue.
- br_taken  input  1  core reports taken branch for the current instr_out.
- br_offset  input  8  signed branch offset from the core (r3 value).
- instr_out  output  IW  instruction presented to core.
- instr_valid  output  1  instr_out is live.
- issue_addr  output  AW  program address of instr_out.
- prog_len  output  AW+1  number of stored words, 0..DEPTH.
- halted  output  1  program ran off its end.
- overflow  output  1  sticky: a load was dropped because the store was full.

Behaviour:
- Reset (async, rst_n=0): state IDLE; instr_out=0, instr_valid=0, issue_addr=0, prog_len=0, halted=0, overflow=0, internal write and fetch pointers 0. Store contents are not cleared.
- States: IDLE, LOAD, RUN, HALT. load_en has priority over run in IDLE.
- IDLE:
  - load_en=1 -> LOAD; clears prog_len, write pointer and overflow.
  - Else run=1 and prog_len>0 -> RUN.
  - Else run=1 and prog_len=0 -> stay IDLE.
- LOAD:
  - Each cycle with load_valid=1 and prog_len<DEPTH: mem[wr_ptr]<=load_data, wr_ptr++, prog_len++.
  - At prog_len=DEPTH a load_valid write is dropped and overflow is set.
  - load_en=0 -> IDLE; a load_valid on that same cycle is ignored.
- RUN:
  - Synchronous-read store. The first instr_valid=1 appears 1 cycle after entering RUN, carrying mem[0] with issue_addr=0.
  - stall=1: instr_out, issue_addr, instr_valid and the fetch pointer hold. br_taken is ignored.
  - stall=0, br_taken=0: next issued word is issue_addr+1.
  - stall=0, br_taken=1: next issued address is (issue_addr + br_offset) truncated to AW bits (mod DEPTH, two's complement). Branch costs no bubble.
  - End of program: the next address is >= prog_len, either by sequential advance past the last word or by branch target.
    - Without the optional feature: -> HALT. instr_valid=0 and halted=1 on the following cycle; the last valid word is issued normally.
  - run=0 (checked before stall): -> IDLE; instr_valid=0 next cycle.
  - load_en=1 while running: ignored until IDLE.
- HALT: instr_valid=0, halted=1. run=0 -> IDLE, which clears halted.
- Reset mid-LOAD or mid-RUN: immediate return to IDLE; prog_len=0, so the partial program is discarded.

Optional Feature:
- Macro HIDDENCPU_FETCH_LOOP_EN.
- Defined: the end-of-program condition wraps the next address to 0 instead of entering HALT, so the program loops forever. halted is tied 0 and HALT is unreachable.
- Undefined: HALT behaviour as above.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, HALT=2'd3;
  - NOP_WORD=6'b0 (value driven on instr_out at reset);
  - IW default.
- One natural sub-module: hiddencpu_prog_ram, DEPTH x IW, one synchronous write port and one registered read port with read-enable, so stall can hold the read.
- Top holds the FSM, the pointers and the branch adder.

Test Plan:
- Reset then load 3 words 0x11, 0x22, 0x33, run=1 -> instr_out 0x11, 0x22, 0x33 with issue_addr 0, 1, 2 on consecutive cycles. Then instr_valid=0, halted=1; prog_len=3.
- Load 17 words with DEPTH=16 -> prog_len=16, overflow=1, 17th word absent. Replay yields the first 16 words in order.
- Run 8-word program; stall=1 for 3 cycles while issuing addr 2 -> instr_out/issue_addr held at addr 2 for 4 cycles total. Resumes with addr 3. br_taken asserted during stall has no effect.
- Run 8-word program; br_taken=1 with br_offset=8'hFE at issue_addr 5 -> next issue_addr 3. br_offset=8'd4 at addr 5 (target 9 >= 8) -> HALT. With HIDDENCPU_FETCH_LOOP_EN -> next issue_addr 0.
- rst_n pulsed low mid-RUN at addr 4 -> outputs return to reset values immediately, prog_len=0. run=1 afterwards stays IDLE with instr_valid=0.
- With HIDDENCPU_FETCH_LOOP_EN, 2-word program 0x05, 0x0A -> sequence 0x05, 0x0A, 0x05, 0x0A for 10 cycles; halted stays 0.
